// File: rtl/soc_lsu.sv
// ============================================================================
// soc_lsu : byte/half/word load-store unit with split misaligned accesses
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module soc_lsu #(
    parameter bit p_allow_misaligned = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_valid,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [29:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_wr_data,
    output logic        o_mem_rd_en,
    input  logic [31:0] i_mem_rd_data,
    input  logic        i_mem_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE0 = 2'd1,
        ISSUE1 = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] lo_q;
    logic [31:0] rdata_q;

    logic        w_req_misal;
    logic        w_req_err;
    logic [2:0]  w_bytes;
    logic [3:0]  w_mask4;
    logic [1:0]  w_off;
    logic        w_split;
    logic [7:0]  w_mask8;
    logic [63:0] w_wide;
    logic [63:0] w_merged;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    assign w_req_misal = ((i_size == 2'b01) && i_addr[0]) ||
                         ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));
    assign w_req_err   = (i_size == 2'b11) || (!p_allow_misaligned && w_req_misal);

    always_comb begin
        w_bytes = 3'd4;
        w_mask4 = 4'b1111;
        case (size_q)
            2'b00:   begin w_bytes = 3'd1; w_mask4 = 4'b0001; end
            2'b01:   begin w_bytes = 3'd2; w_mask4 = 4'b0011; end
            default: begin w_bytes = 3'd4; w_mask4 = 4'b1111; end
        endcase
    end

    assign w_off    = addr_q[1:0];
    assign w_split  = ({1'b0, w_off} + w_bytes) > 3'd4;
    assign w_mask8  = {4'b0000, w_mask4} << w_off;
    assign w_wide   = {32'b0, wdata_q} << {w_off, 3'b000};

    // lo_q holds word 0 of a split load; the live RAM output is word 1
    assign w_merged = w_split ? {i_mem_rd_data, lo_q} : {32'b0, i_mem_rd_data};
    assign w_shift  = 32'(w_merged >> {w_off, 3'b000});

    always_comb begin
        w_load = w_shift;
        case (size_q)
            2'b00:   w_load = {{24{~uns_q & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_load = {{16{~uns_q & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        o_ready       = 1'b0;
        o_valid       = 1'b0;
        o_err         = 1'b0;
        o_mem_addr    = 30'd0;
        o_mem_be      = 4'd0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_data = 32'd0;
        o_mem_rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_req) begin
                    state_d = w_req_err ? RESP : ISSUE0;
                end
            end
            ISSUE0: begin
                o_mem_addr    = addr_q[31:2];
                o_mem_be      = w_mask8[3:0];
                o_mem_wr_data = w_wide[31:0];
                o_mem_wr_en   = we_q;
                o_mem_rd_en   = ~we_q;
                if (!i_mem_busy) begin
                    state_d = w_split ? ISSUE1 : RESP;
                end
            end
            ISSUE1: begin
                o_mem_addr    = addr_q[31:2] + 30'd1;
                o_mem_be      = w_mask8[7:4];
                o_mem_wr_data = w_wide[63:32];
                o_mem_wr_en   = we_q;
                o_mem_rd_en   = ~we_q;
                if (!i_mem_busy) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                o_valid = 1'b1;
                o_err   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            lo_q    <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && i_req) begin
                we_q    <= i_we;
                addr_q  <= i_addr;
                size_q  <= i_size;
                uns_q   <= i_unsigned;
                wdata_q <= i_wdata;
                err_q   <= w_req_err;
            end
            if ((state_q == ISSUE1) && !i_mem_busy && !we_q) begin
                lo_q <= i_mem_rd_data;
            end
            if ((state_q == RESP) && !we_q && !err_q) begin
                rdata_q <= w_load;
            end
        end
    end

    assign o_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_lsu.sv
// ============================================================================
// tb_soc_lsu : directed self-checking bench for soc_lsu with a small RAM model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_soc_lsu;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_wdata;
    logic        i_mem_busy;
    logic [31:0] mem_rd_data;

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;
    logic [29:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic        o_mem_wr_en, o_mem_rd_en;
    logic [31:0] o_mem_wr_data;

    logic        w0_ready, w0_valid, w0_err;
    logic [31:0] w0_rdata;
    logic [29:0] w0_mem_addr;
    logic [3:0]  w0_mem_be;
    logic        w0_mem_wr_en, w0_mem_rd_en;
    logic [31:0] w0_mem_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    soc_lsu #(.p_allow_misaligned(1'b1)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_size(i_size), .i_unsigned(i_unsigned), .i_wdata(i_wdata),
        .o_ready(o_ready), .o_valid(o_valid), .o_err(o_err), .o_rdata(o_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wr_en(o_mem_wr_en),
        .o_mem_wr_data(o_mem_wr_data), .o_mem_rd_en(o_mem_rd_en),
        .i_mem_rd_data(mem_rd_data), .i_mem_busy(i_mem_busy)
    );

    // Strict-alignment instance sharing the request stream; its RAM port is only observed
    soc_lsu #(.p_allow_misaligned(1'b0)) u_dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_size(i_size), .i_unsigned(i_unsigned), .i_wdata(i_wdata),
        .o_ready(w0_ready), .o_valid(w0_valid), .o_err(w0_err), .o_rdata(w0_rdata),
        .o_mem_addr(w0_mem_addr), .o_mem_be(w0_mem_be), .o_mem_wr_en(w0_mem_wr_en),
        .o_mem_wr_data(w0_mem_wr_data), .o_mem_rd_en(w0_mem_rd_en),
        .i_mem_rd_data(mem_rd_data), .i_mem_busy(i_mem_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [31:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    always @(posedge i_clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (!i_mem_busy) begin
            if (o_mem_wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (o_mem_be[b]) mem[o_mem_addr[5:0]][8*b +: 8] <= o_mem_wr_data[8*b +: 8];
                end
            end
            if (o_mem_rd_en) mem_rd_data <= mem[o_mem_addr[5:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input logic [5:0] idx, input logic [31:0] val);
        @(negedge i_clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(posedge i_clk);
        #1 pl_en = 1'b0;
    endtask

    logic [29:0] tx_addr [2];
    logic [3:0]  tx_be   [2];
    logic [31:0] tx_data [2];
    logic        tx_we   [2];
    int          ntx, lat, lat0;
    logic        verr, verr0, en0_seen, held_ok, rdy_k1;

    task automatic access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int nbusy);
        logic        prev_busy;
        logic [67:0] snap;
        ntx = 0; lat = 0; lat0 = 0; verr = 1'b0; verr0 = 1'b0;
        en0_seen = 1'b0; held_ok = 1'b1; prev_busy = 1'b0; snap = '0; rdy_k1 = 1'b1;
        @(negedge i_clk);
        i_req = 1'b1; i_we = we; i_addr = addr; i_size = size; i_unsigned = uns; i_wdata = wdata;
        @(posedge i_clk);
        #1;
        i_req = 1'b0; i_wdata = 32'h5A5A_5A5A; i_addr = 32'hFFFF_FFF0; i_size = 2'b11;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge i_clk);
            if (k == 1) rdy_k1 = o_ready;
            i_mem_busy = (k <= nbusy);
            if (prev_busy && ({o_mem_addr, o_mem_be, o_mem_wr_data, o_mem_wr_en, o_mem_rd_en} !== snap))
                held_ok = 1'b0;
            snap      = {o_mem_addr, o_mem_be, o_mem_wr_data, o_mem_wr_en, o_mem_rd_en};
            prev_busy = i_mem_busy;
            if ((o_mem_wr_en || o_mem_rd_en) && !i_mem_busy) begin
                if (ntx < 2) begin
                    tx_addr[ntx] = o_mem_addr;
                    tx_be[ntx]   = o_mem_be;
                    tx_data[ntx] = o_mem_wr_data;
                    tx_we[ntx]   = o_mem_wr_en;
                end
                ntx++;
            end
            if (o_valid) begin lat = k; verr = o_err; end
            if (w0_valid && lat0 == 0) begin lat0 = k; verr0 = w0_err; end
            if (w0_mem_wr_en || w0_mem_rd_en) en0_seen = 1'b1;
        end
        i_mem_busy = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    int nvalid;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_size = '0;
        i_unsigned = 1'b0; i_wdata = '0; i_mem_busy = 1'b0; pl_en = 1'b0;
        pl_idx = '0; pl_val = '0;
        #12;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid_err", {30'd0, o_valid, o_err}, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_mem_ctl", {o_mem_addr, o_mem_wr_en, o_mem_rd_en}, 32'd0);
        check("rst_mem_be_data", {28'd0, o_mem_be} | o_mem_wr_data, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // aligned word load
        set_mem(6'd16, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'd0, 0);
        check("lw_lat", lat, 32'd2);
        check("lw_ready_busy", {31'd0, rdy_k1}, 32'd0);
        check("lw_ntx", ntx, 32'd1);
        check("lw_addr", tx_addr[0], 32'h10);
        check("lw_be", tx_be[0], 32'hF);
        check("lw_we", tx_we[0], 32'd0);
        check("lw_err", verr, 32'd0);
        check("lw_rdata", o_rdata, 32'hDEAD_BEEF);
        check("lw_pulse", {30'd0, o_valid, o_ready}, 32'd1);

        // signed / unsigned byte
        set_mem(6'd16, 32'h0000_8000);
        access(1'b0, 32'h0000_0041, 2'b00, 1'b0, 32'd0, 0);
        check("lb_be", tx_be[0], 32'b0010);
        check("lb_rdata", o_rdata, 32'hFFFF_FF80);
        access(1'b0, 32'h0000_0041, 2'b00, 1'b1, 32'd0, 0);
        check("lbu_rdata", o_rdata, 32'h0000_0080);

        // split store
        set_mem(6'd0, 32'h1122_3344);
        set_mem(6'd1, 32'h5566_7788);
        access(1'b1, 32'h0000_0103, 2'b10, 1'b0, 32'hAABB_CCDD, 0);
        check("sw_lat", lat, 32'd3);
        check("sw_ntx", ntx, 32'd2);
        check("sw_addr0", tx_addr[0], 32'h40);
        check("sw_be0", tx_be[0], 32'b1000);
        check("sw_data0", tx_data[0], 32'hDD00_0000);
        check("sw_we0", tx_we[0], 32'd1);
        check("sw_addr1", tx_addr[1], 32'h41);
        check("sw_be1", tx_be[1], 32'b0111);
        check("sw_data1", tx_data[1], 32'h00AA_BBCC);
        check("sw_mem0", mem[0], 32'hDD22_3344);
        check("sw_mem1", mem[1], 32'h55AA_BBCC);
        check("sw_rdata_kept", o_rdata, 32'h0000_0080);
        check("sw_strict_lat", lat0, 32'd1);
        check("sw_strict_err", verr0, 32'd1);
        check("sw_strict_noen", en0_seen, 32'd0);

        // split half load
        set_mem(6'd1, 32'h1134_5678);
        set_mem(6'd2, 32'h9ABC_DE22);
        access(1'b0, 32'h0000_0007, 2'b01, 1'b1, 32'd0, 0);
        check("lhu_split_lat", lat, 32'd3);
        check("lhu_split_addr", {tx_addr[0][15:0], tx_addr[1][15:0]}, 32'h0001_0002);
        check("lhu_split_be", {tx_be[0], tx_be[1]}, 32'h81);
        check("lhu_split_rdata", o_rdata, 32'h0000_2211);
        check("lh_strict_err", {lat0[7:0], 7'd0, verr0}, {8'd1, 8'd1});
        access(1'b0, 32'h0000_0007, 2'b01, 1'b0, 32'd0, 0);
        check("lh_split_rdata", o_rdata, 32'h0000_2211);
        set_mem(6'd2, 32'h0000_00A2);
        access(1'b0, 32'h0000_0007, 2'b01, 1'b0, 32'd0, 0);
        check("lh_split_neg", o_rdata, 32'hFFFF_A211);

        // wrap at the top of the address space
        set_mem(6'd63, 32'h7F00_0000);
        set_mem(6'd0, 32'h0000_00C3);
        access(1'b0, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'd0, 0);
        check("wrap_addr0", tx_addr[0], 32'h3FFF_FFFF);
        check("wrap_addr1", tx_addr[1], 32'h0);
        check("wrap_rdata", o_rdata, 32'hFFFF_C37F);

        // illegal size
        access(1'b1, 32'h0000_0040, 2'b11, 1'b0, 32'h1234_5678, 0);
        check("ill_lat", lat, 32'd1);
        check("ill_err", verr, 32'd1);
        check("ill_ntx", ntx, 32'd0);
        check("ill_mem", mem[16], 32'h0000_8000);
        check("ill_rdata", o_rdata, 32'hFFFF_C37F);

        // misaligned word: split on one instance, error on the strict one
        set_mem(6'd0, 32'h4433_2211);
        set_mem(6'd1, 32'h8877_6655);
        access(1'b0, 32'h0000_0002, 2'b10, 1'b0, 32'd0, 0);
        check("mis_lat", lat, 32'd3);
        check("mis_rdata", o_rdata, 32'h6655_4433);
        check("mis_strict_lat", lat0, 32'd1);
        check("mis_strict_err", verr0, 32'd1);
        check("mis_strict_noen", en0_seen, 32'd0);
        check("mis_strict_rdata", w0_rdata, 32'h0000_0080);

        // busy stall in the first transaction
        set_mem(6'd16, 32'hCAFE_F00D);
        access(1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'd0, 2);
        check("busy_lat", lat, 32'd4);
        check("busy_held", held_ok, 32'd1);
        check("busy_ntx", ntx, 32'd1);
        check("busy_rdata", o_rdata, 32'hCAFE_F00D);

        // reset during the second half of a split load
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0007; i_size = 2'b01; i_unsigned = 1'b1;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        @(posedge i_clk);
        #1;
        check("rstmid_issue1", {o_mem_addr, o_mem_rd_en}, {30'd2, 1'b1});
        i_rst_n = 1'b0;
        #1;
        check("rstmid_ctl", {o_mem_addr, o_mem_wr_en, o_mem_rd_en}, 32'd0);
        check("rstmid_be", {28'd0, o_mem_be}, 32'd0);
        check("rstmid_rdata", o_rdata, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            if (o_valid) nvalid++;
        end
        check("rstmid_novalid", nvalid, 32'd0);
        check("rstmid_ready", {31'd0, o_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/soc_lsu.md
# soc_lsu

Load/store unit between the core's data-access port and the single-port 32-bit data RAM. It converts byte/half/word load and store requests into word-addressed RAM transactions with byte enables. It splits misaligned accesses that cross a word boundary into two consecutive RAM transactions. It aligns and sign- or zero-extends returned load data. The RAM side assumes a registered read port: data appears the cycle after `rd_en` and holds until the next read.

## Interface
- p_allow_misaligned, 1, 1: boundary-crossing accesses are split into two transactions; 0: any misaligned access is flagged as an error.
- i_clk  in  1  global clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_req  in  1  access request; sampled only while o_ready=1
- i_we  in  1  1 = store, 0 = load
- i_addr  in  32  byte address
- i_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_unsigned  in  1  load zero-extend (1) / sign-extend (0)
- i_wdata  in  32  store data, right-justified
- o_ready  out  1  request can be accepted (state IDLE)
- o_valid  out  1  one-cycle completion strobe
- o_err  out  1  qualified by o_valid; illegal size or disallowed misalignment
- o_rdata  out  32  extended load result; held between strobes
- o_mem_addr  out  30  RAM word address [31:2]
- o_mem_be  out  4  RAM byte enables
- o_mem_wr_en  out  1  RAM write enable
- o_mem_wr_data  out  32  RAM write data, lane-aligned
- o_mem_rd_en  out  1  RAM read enable
- i_mem_rd_data  in  32  RAM read data
- i_mem_busy  in  1  RAM stall; the current transaction is held and repeated

## Operation
- States: IDLE, ISSUE0, ISSUE1, RESP.
- IDLE: o_ready=1. On i_req, latch we/addr/size/unsigned/wdata.
  - Illegal size → RESP with err.
  - Misaligned while p_allow_misaligned=0 → RESP with err. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise → ISSUE0.
- Sizing: bytes = 1/2/4; off = addr[1:0]; split = (off+bytes > 4).
- Byte-enable mask: 8-bit mask = ((1<<bytes)-1) << off.
- Write data: 64-bit wide = {32'b0, wdata} << (8·off).
- ISSUE0:
  - Drive o_mem_addr=addr[31:2], be=mask[3:0], wr_data=wide[31:0].
  - Drive wr_en=we or rd_en=!we.
  - If i_mem_busy, hold. Else → ISSUE1 if split, else RESP.
- ISSUE1:
  - Drive o_mem_addr=addr[31:2]+1, wrapping 0x3FFFFFFF→0.
  - Drive be=mask[7:4], wr_data=wide[63:32], with the same enable.
  - For loads, on the exiting edge (busy=0) register lo ← i_mem_rd_data, which still holds word 0. Then → RESP.
- RESP:
  - o_valid=1. For loads, merged = ({i_mem_rd_data, lo} if split, else {32'b0, i_mem_rd_data}) >> (8·off).
  - o_rdata ← low `bytes` bytes of merged, extended per i_unsigned.
  - Stores and errors leave o_rdata unchanged.
  - → IDLE.
- RAM outputs are zero in IDLE and RESP.
- No memory access is issued for error requests.

## Timing
- Reset (async, i_rst_n=0): state=IDLE. o_ready=1; o_valid=0, o_err=0, o_rdata=0; all o_mem_* = 0; lo=0.
- Reset mid-operation: enables drop immediately. No o_valid is produced and the pending access is discarded.
- Latency, measured from the acceptance cycle N with no busy:
  - aligned / non-split: o_valid at N+2;
  - split: o_valid at N+3;
  - error: o_valid at N+1.
- Each busy cycle in ISSUE0/ISSUE1 adds one cycle.
- Throughput: at most one request per 3 cycles for a non-split access; o_ready=0 outside IDLE.
- i_req while o_ready=0 is ignored. The core must hold it until it is accepted.
- Request inputs are don't-care after acceptance.
- o_valid is a single-cycle pulse.
- o_err is 0 whenever o_valid=0.

## Test plan
- Aligned word load: RAM[0x40>>2]=0xDEADBEEF, load word 0x40 → rd_en at N+1 with be=1111, o_valid at N+2, o_rdata=0xDEADBEEF.
- Signed vs unsigned byte: word=0x00008000, load byte at 0x41 signed → 0xFFFFFF80; unsigned → 0x00000080.
- Split store, word 0xAABBCCDD to addr 0x103:
  - cycle 1: addr 0x40, be=1000, data[31:24]=0xDD;
  - cycle 2: addr 0x41, be=0111, data[23:0]=0xAABBCC;
  - o_valid at N+3.
- Split load, half at 0x07: word1=0x11xxxxxx, word2=0xxxxxxx22 → unsigned 0x00002211, signed 0x00002211; wrap case addr 0xFFFFFFFF issues word addrs 0x3FFFFFFF then 0x0.
- Errors: size=11, or word at 0x02 with p_allow_misaligned=0 → o_valid+o_err at N+1, no wr_en/rd_en ever, o_rdata unchanged.
- Busy and reset:
  - Busy: i_mem_busy high 2 cycles during ISSUE0 → outputs held stable, o_valid delayed 2 cycles.
  - Reset: i_rst_n low during ISSUE1 → all outputs 0 asynchronously, o_ready=1 after release, no o_valid.
